// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared types and helpers for the adder scheduler.
//   DATA_W_DEF - default operand/result width
//   state_e    - scheduler FSM states
//   tag_t      - in-flight tag {valid, owning requester index}
//   get_slice  - extracts requester r's operand from a packed operand bus
package add_sched_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  // Upper bounds used to size the generic slice helper.
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned MAX_W   = 32;
  localparam int unsigned PAD_W   = MAX_REQ * MAX_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } tag_t;

  // Bus is zero-padded to PAD_W by the caller; width is the real slice width.
  function automatic logic [MAX_W-1:0] get_slice(input logic [PAD_W-1:0] bus,
                                                 input int unsigned width,
                                                 input int unsigned r);
    logic [MAX_W-1:0] s;
    s = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if ((i < width) && ((r * width + i) < PAD_W)) begin
        s[5'(i)] = bus[8'(r * width + i)];
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: combinational round-robin arbiter.
//   req   - per-requester request vector
//   prio  - index that holds highest priority this cycle
//   en    - grants are suppressed when low
//   grant - one-hot grant (all zero when nothing granted)
//   idx   - index of the granted requester (0 when nothing granted)
module add_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         prio,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         idx
);

  logic found;

  // Scan offsets from prio upward; the first requesting index wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      for (int c = 0; c < int'(NUM_REQ); c++) begin
        if (en && !found && req[c] && (c == ((int'(prio) + k) % int'(NUM_REQ)))) begin
          grant[c] = 1'b1;
          idx      = 3'(c);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one adder among NUM_REQ requesters.
//   clk_i, reset_i (sync, active-low)
//   start_i, op_count_i          - run control; count latched on an accepted start
//   req_valid_i/req_a_i/req_b_i  - per-requester operand offers (slice r = requester r)
//   req_ready_o                  - per-requester accept (one-hot, RUN only)
//   op_valid_o/op_a_o/op_b_o     - registered issue to the adder
//   res_i                        - adder result, ADD_LAT cycles after op_valid_o
//   rsp_valid_o/rsp_data_o       - registered one-hot result return to the owner
//   busy_o                       - high in RUN and DRAIN
//   done_o                       - one-cycle pulse at run completion
// Optional feature macro ADD_SCHED_STATS_EN adds stat_issue_o (per-requester
// saturating issue counters, cleared on an accepted start).
module add_sched
  import add_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic [31:0]               op_count_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      op_valid_o,
  output logic [DATA_W-1:0]         op_a_o,
  output logic [DATA_W-1:0]         op_b_o,
  input  logic [DATA_W-1:0]         res_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef ADD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]     stat_issue_o
`endif
);

  localparam int unsigned TagDepth = ADD_LAT + 1;

  state_e              state_q, state_d;
  logic [31:0]         count_q, issued_q;
  logic [2:0]          prio_q;
  logic [NUM_REQ-1:0]  grant;
  logic [2:0]          gidx;
  logic                xfer;
  logic                start_ok;
  logic                drain_empty;
  tag_t                tag_q [TagDepth];

  logic                op_valid_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                busy_q, done_q;

  logic [PAD_W-1:0]    a_pad, b_pad;
  logic [DATA_W-1:0]   gnt_a, gnt_b;

  add_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req   (req_valid_i),
    .prio  (prio_q),
    .en    (state_q == StRun),
    .grant (grant),
    .idx   (gidx)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign xfer        = |grant;
  assign req_ready_o = grant;
  assign start_ok    = (state_q == StIdle) && start_i;

  assign a_pad = PAD_W'(req_a_i);
  assign b_pad = PAD_W'(req_b_i);
  assign gnt_a = DATA_W'(get_slice(a_pad, DATA_W, 32'(gidx)));
  assign gnt_b = DATA_W'(get_slice(b_pad, DATA_W, 32'(gidx)));

  // Tags before the aligned stage are results still to arrive; once those are
  // gone the last result is being captured this cycle.
  always_comb begin
    drain_empty = 1'b1;
    for (int k = 0; k < int'(ADD_LAT); k++) begin
      if (tag_q[k].vld) drain_empty = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = (op_count_i == 32'd0) ? StDone : StRun;
      StRun:   if (xfer && ((issued_q + 32'd1) == count_q)) state_d = StDrain;
      StDrain: if (drain_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      count_q     <= '0;
      issued_q    <= '0;
      prio_q      <= '0;
      op_valid_q  <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < int'(TagDepth); k++) tag_q[k] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_q == StDone);

      if (start_ok) begin
        count_q  <= op_count_i;
        issued_q <= '0;
      end else if (xfer) begin
        issued_q <= issued_q + 32'd1;
      end

      if (xfer) begin
        prio_q <= (gidx == 3'(NUM_REQ - 1)) ? 3'd0 : gidx + 3'd1;
        op_a_q <= gnt_a;
        op_b_q <= gnt_b;
      end
      op_valid_q <= xfer;

      tag_q[0] <= '{vld: xfer, idx: gidx};
      for (int k = 1; k < int'(TagDepth); k++) tag_q[k] <= tag_q[k-1];

      if (tag_q[ADD_LAT].vld) begin
        rsp_valid_q <= NUM_REQ'(1) << tag_q[ADD_LAT].idx;
        rsp_data_q  <= res_i;
      end else begin
        rsp_valid_q <= '0;
      end
    end
  end

  assign op_valid_o  = op_valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

`ifdef ADD_SCHED_STATS_EN
  logic [31:0] stat_q [NUM_REQ];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int r = 0; r < int'(NUM_REQ); r++) stat_q[r] <= '0;
    end else if (start_ok) begin
      for (int r = 0; r < int'(NUM_REQ); r++) stat_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        if (grant[r] && (stat_q[r] != 32'hFFFF_FFFF)) stat_q[r] <= stat_q[r] + 32'd1;
      end
    end
  end

  for (genvar r = 0; r < int'(NUM_REQ); r++) begin : g_stat
    assign stat_issue_o[r*32 +: 32] = stat_q[r];
  end
`endif

endmodule

// File: doc/add_sched.md
# add_sched

Round-robin scheduler that shares the single 8-bit adder BFM among several stimulus requesters. Each requester offers operand pairs over a valid/ready handshake; the block issues at most one pair per cycle to the adder's A/B inputs. It tags each issue with the requester index, returns each adder result to its owner, and bounds each run by a programmed operation count. It sits between the testbench stimulus sources and the adder, replacing the single free-running pointer feeder.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand and result width
- ADD_LAT, 1, adder latency in cycles from op_valid_o to a valid res_i (1..4)
- clk_i  in  1  single clock; all logic on its rising edge
- reset_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle pulse that starts a run; honoured only in IDLE
- op_count_i  in  32  number of operations in the run; latched on start_i
- req_valid_i  in  NUM_REQ  per-requester operand valid
- req_a_i, req_b_i  in  NUM_REQ*DATA_W  packed operands; requester r occupies slice r
- req_ready_o  out  NUM_REQ  per-requester accept
- op_valid_o  out  1  issue strobe to the adder
- op_a_o, op_b_o  out  DATA_W  operands to the adder (A_s/B_s)
- res_i  in  DATA_W  adder result
- rsp_valid_o  out  NUM_REQ  one-hot result strobe to the owning requester
- rsp_data_o  out  DATA_W  returned result
- busy_o  out  1  high in RUN and DRAIN
- done_o  out  1  one-cycle pulse at run completion

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
  - IDLE→RUN on start_i. If op_count_i==0, IDLE→DONE instead.
  - RUN→DRAIN on the cycle the issued count reaches the latched count.
  - DRAIN→DONE when no tag is in flight.
  - DONE→IDLE unconditionally after one cycle.
- Arbitration:
  - Combinational round-robin over req_valid_i, starting at priority pointer prio.
  - req_ready_o[r] = (state==RUN) && grant[r]. At most one bit is set.
  - A transfer occurs when valid & ready. After a grant to r, prio = (r+1) mod NUM_REQ.
  - With no valid requester, prio holds.
- Issue:
  - op_valid_o, op_a_o and op_b_o are registered.
  - On a transfer they load the granted slice; otherwise op_valid_o=0 and the operands hold their values.
- Tag pipeline:
  - Depth ADD_LAT+1. It carries {valid, requester index} aligned with res_i.
  - At the aligned stage, rsp_valid_o[idx] and rsp_data_o=res_i are registered.
- Responses have no backpressure; requesters must always accept them.
- The issued counter is 32-bit and cleared on start. The comparison is equality, so the counter never wraps within a run.
- start_i outside IDLE is ignored. It is not queued.
- A requester holding valid during DRAIN, DONE or IDLE is never granted.
- Reset asserted mid-run:
  - Returns to IDLE and clears all tags.
  - In-flight results are discarded and no rsp_valid_o is produced.
- Reset values:
  - Outputs: op_valid_o=0, op_a_o=0, op_b_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=0, done_o=0, req_ready_o=0.
  - Internal: prio=0.

## Timing
- Handshake in cycle T gives op_valid_o at T+1 and res_i valid at T+1+ADD_LAT.
- rsp_valid_o follows at T+2+ADD_LAT, so request-to-response latency is ADD_LAT+2.
- Sustained throughput is one issue per cycle with any valid requester present.
- done_o pulses one cycle after the last response's rsp_valid_o cycle.
- For op_count_i==0, done_o pulses 2 cycles after start_i.
- busy_o is registered from state and is high from T_start+1 until DONE.

## Configuration
- ADD_SCHED_STATS_EN defined:
  - Adds output stat_issue_o (NUM_REQ*32), one issue counter per requester.
  - Counters clear on start_i accepted in IDLE and saturate at 32'hFFFF_FFFF.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Structure
- Package add_sched_pkg holds:
  - DATA_W_DEF and the state enum (IDLE, RUN, DRAIN, DONE).
  - tag_t struct {logic vld; logic [2:0] idx}.
  - The function that extracts slice r from the packed operand buses.
- Sub-module add_rr_arbiter is parameterised by NUM_REQ:
  - Inputs: req, prio, en.
  - Outputs: one-hot grant and the granted index.
  - Purely combinational. prio is a register in add_sched.

## Test plan
- NUM_REQ=4, ADD_LAT=1, all four valid constantly, op_count=8:
  - Grants go 0,1,2,3,0,1,2,3.
  - Responses return in the same order, each 3 cycles after its handshake.
  - done_o pulses once, then busy_o=0.
- Only requester 2 valid with A=200, B=100, op_count=1:
  - rsp_valid_o=4'b0100 and rsp_data_o=44 (mod 256) at T+3.
  - done_o follows one cycle later.
- op_count=0:
  - No req_ready_o ever asserted.
  - done_o pulses 2 cycles after start_i.
- reset_i low during RUN with 2 ops in flight:
  - No rsp_valid_o afterwards, state IDLE, prio=0.
  - A new start_i behaves as from reset.
- start_i pulsed during DRAIN:
  - Ignored: run completes with the original count and a single done_o.
- Requester 1 valid only on alternate cycles, requester 3 valid constantly:
  - Requester 1 is never starved; each of its transfers occurs within 2 cycles of its valid rising.
